// File: rtl/hangmaze_num_pkg.sv
// Shared numeric types and constants for the hangmaze BCD/binary conversion blocks.
// Holds the converter state encoding and the BCD digit limits used by the adjust step.
package hangmaze_num_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_t;

   localparam int                 DIGIT_W        = 4;
   localparam logic [DIGIT_W-1:0] BCD_MAX        = 4'd9;
   localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd8;
   localparam logic [DIGIT_W-1:0] BCD_ADJ        = 4'd3;

   // Bits needed to hold the largest value expressible in num_digits decimal digits.
   function automatic int min_bin_w(input int num_digits);
      longint max_val;
      int     w;
      max_val = 1;
      w       = 0;
      for (int i = 0; i < num_digits; i++) begin
         max_val = max_val * 10;
      end
      max_val = max_val - 1;
      for (int b = 0; b < 64; b++) begin
         if (max_val > 0) begin
            w       = w + 1;
            max_val = max_val >> 1;
         end
      end
      return (w == 0) ? 1 : w;
   endfunction

endpackage

// File: rtl/decimal_to_hex_seq_digit_adjust.sv
// Per-digit correction for reverse double-dabble: subtracts 3 from a digit >= 8.
// Purely combinational, no handshake.
module bcd_digit_adjust
   import hangmaze_num_pkg::*;
(
   input  logic [DIGIT_W-1:0] digit_in,
   output logic [DIGIT_W-1:0] digit_out
);

   always_comb begin
      digit_out = digit_in;
      if (digit_in >= BCD_ADJ_THRESH) begin
         digit_out = digit_in - BCD_ADJ;
      end
   end

endmodule

// File: rtl/decimal_to_hex_seq.sv
// BCD-to-binary converter, one shift/adjust step per clock; result BIN_W cycles after accept.
// Accepts only in IDLE; holds the result in DONE until out_ready, no accept during the handshake.
module decimal_to_hex_seq
   import hangmaze_num_pkg::*;
#(
   parameter int NUM_DIGITS = 2,
   parameter int BIN_W      = 7
) (
   input  logic                          Clk,
   input  logic                          Reset_n,
   input  logic [DIGIT_W*NUM_DIGITS-1:0] bcd_in,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic [BIN_W-1:0]              bin_out,
   output logic                          err_out,
   output logic                          out_valid,
   input  logic                          out_ready
);

   localparam int BCD_W = DIGIT_W * NUM_DIGITS;
   localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

   if (BIN_W < min_bin_w(NUM_DIGITS)) begin : g_bad_width
      $error("decimal_to_hex_seq: BIN_W too small for NUM_DIGITS");
   end

   conv_state_t             state_q;
   conv_state_t             state_d;
   logic [BCD_W-1:0]        bcd_q;
   logic [BIN_W-1:0]        bin_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    err_q;
   logic [BCD_W+BIN_W-1:0]  shifted;
   logic [BCD_W-1:0]        bcd_adj;
   logic [NUM_DIGITS-1:0]   digit_bad;
   logic                    last_step;

   assign shifted   = {bcd_q, bin_q} >> 1;
   assign last_step = (cnt_q == CNT_W'(BIN_W - 1));

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
      bcd_digit_adjust u_adj (
         .digit_in  (shifted[BIN_W + g*DIGIT_W +: DIGIT_W]),
         .digit_out (bcd_adj[g*DIGIT_W +: DIGIT_W])
      );
      assign digit_bad[g] = (bcd_in[g*DIGIT_W +: DIGIT_W] > BCD_MAX);
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = (|digit_bad) ? DONE : SHIFT;
         SHIFT:   if (last_step) state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         bcd_q <= '0;
         bin_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  bcd_q <= bcd_in;
                  bin_q <= '0;
                  cnt_q <= '0;
                  err_q <= |digit_bad;
               end
            end
            SHIFT: begin
               bcd_q <= bcd_adj;
               bin_q <= shifted[BIN_W-1:0];
               cnt_q <= cnt_q + CNT_W'(1);
               // Leftover BCD after the final shift means the value did not fit in BIN_W.
               if (last_step) begin
                  err_q <= |bcd_adj;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      in_ready  = (state_q == IDLE);
      out_valid = (state_q == DONE);
      bin_out   = (state_q == DONE) ? bin_q : '0;
      err_out   = (state_q == DONE) && err_q;
   end

endmodule

// File: tb/tb_decimal_to_hex_seq.sv
// Directed bench for decimal_to_hex_seq: default 2-digit instance plus a 3-digit/10-bit instance.
module tb_decimal_to_hex_seq;

   logic        clk;
   logic        rst_n;

   logic [7:0]  bcd_a;
   logic        in_valid_a;
   logic        in_ready_a;
   logic [6:0]  bin_a;
   logic        err_a;
   logic        out_valid_a;
   logic        out_ready_a;

   logic [11:0] bcd_b;
   logic        in_valid_b;
   logic        in_ready_b;
   logic [9:0]  bin_b;
   logic        err_b;
   logic        out_valid_b;
   logic        out_ready_b;

   int n_cmp;
   int n_fail;

   decimal_to_hex_seq dut_a (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .bcd_in    (bcd_a),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .bin_out   (bin_a),
      .err_out   (err_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a)
   );

   decimal_to_hex_seq #(.NUM_DIGITS(3), .BIN_W(10)) dut_b (
      .Clk       (clk),
      .Reset_n   (rst_n),
      .bcd_in    (bcd_b),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .bin_out   (bin_b),
      .err_out   (err_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Launch one conversion on dut_a; lat = edges after the accept edge until out_valid (-1 on timeout).
   task automatic run_a(input logic [7:0] bcd, output int lat);
      bcd_a      = bcd;
      in_valid_a = 1'b1;
      tick();
      in_valid_a = 1'b0;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid_a) begin
            lat = i;
            break;
         end
         tick();
      end
   endtask

   task automatic run_b(input logic [11:0] bcd, output int lat);
      bcd_b      = bcd;
      in_valid_b = 1'b1;
      tick();
      in_valid_b = 1'b0;
      lat = -1;
      for (int i = 0; i < 40; i++) begin
         if (out_valid_b) begin
            lat = i;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_cmp++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || bin_a !== 7'd0 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_a: rdy=%b vld=%b bin=%h err=%b, want 1 0 00 0", in_ready_a, out_valid_a, bin_a, err_a);
      end
      n_cmp++;
      if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || bin_b !== 10'd0 || err_b !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_b: rdy=%b vld=%b bin=%h err=%b, want 1 0 000 0", in_ready_b, out_valid_b, bin_b, err_b);
      end
      #10;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat;
      out_ready_a = 1'b1;
      run_a(8'h42, lat);
      n_cmp++;
      if (lat !== 7) begin n_fail++; $display("FAIL basic_latency: got %0d, want 7", lat); end
      n_cmp++;
      if (bin_a !== 7'h2A || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_value: bin=%h err=%b, want 2a 0", bin_a, err_a);
      end
      tick();
      n_cmp++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_handshake: rdy=%b vld=%b, want 1 0", in_ready_a, out_valid_a);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] vin  [3] = '{8'h00, 8'h99, 8'h10};
      logic [6:0] vexp [3] = '{7'h00, 7'h63, 7'h0A};
      int lat;
      out_ready_a = 1'b1;
      for (int k = 0; k < 3; k++) begin
         run_a(vin[k], lat);
         n_cmp++;
         if (lat !== 7 || bin_a !== vexp[k] || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_%0d: lat=%0d bin=%h err=%b, want 7 %h 0", k, lat, bin_a, err_a, vexp[k]);
         end
         tick();
      end
   endtask

   task automatic test_invalid();
      logic [7:0] vin [2] = '{8'h3A, 8'hF0};
      int lat;
      out_ready_a = 1'b1;
      for (int k = 0; k < 2; k++) begin
         run_a(vin[k], lat);
         n_cmp++;
         if (lat !== 0 || bin_a !== 7'd0 || err_a !== 1'b1) begin
            n_fail++;
            $display("FAIL invalid_%0d: lat=%0d bin=%h err=%b, want 0 00 1", k, lat, bin_a, err_a);
         end
         tick();
         n_cmp++;
         if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0) begin
            n_fail++;
            $display("FAIL invalid_release_%0d: rdy=%b vld=%b, want 1 0", k, in_ready_a, out_valid_a);
         end
      end
   endtask

   task automatic test_backpressure();
      int lat;
      int bad;
      out_ready_a = 1'b0;
      run_a(8'h57, lat);
      n_cmp++;
      if (lat !== 7 || bin_a !== 7'h39 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_result: lat=%0d bin=%h err=%b, want 7 39 0", lat, bin_a, err_a);
      end
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         bcd_a      = 8'(c * 7 + 1);
         in_valid_a = 1'b1;
         tick();
         if (out_valid_a !== 1'b1 || bin_a !== 7'h39 || in_ready_a !== 1'b0 || err_a !== 1'b0) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL bp_hold: %0d unstable cycles, want 0", bad);
      end
      in_valid_a  = 1'b0;
      out_ready_a = 1'b1;
      tick();
      n_cmp++;
      if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: vld=%b rdy=%b, want 0 1", out_valid_a, in_ready_a);
      end
      tick();
      n_cmp++;
      if (out_valid_a !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_single: vld=%b, want 0", out_valid_a);
      end
   endtask

   task automatic test_reset_mid_shift();
      int lat;
      int seen;
      out_ready_a = 1'b1;
      bcd_a       = 8'h64;
      in_valid_a  = 1'b1;
      tick();
      in_valid_a  = 1'b0;
      tick();
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || bin_a !== 7'd0 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset: rdy=%b vld=%b bin=%h err=%b, want 1 0 00 0", in_ready_a, out_valid_a, bin_a, err_a);
      end
      #2;
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 12; c++) begin
         tick();
         if (out_valid_a === 1'b1) seen++;
      end
      n_cmp++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_no_valid: %0d valid cycles, want 0", seen);
      end
      run_a(8'h64, lat);
      n_cmp++;
      if (lat !== 7 || bin_a !== 7'h40 || err_a !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_recover: lat=%0d bin=%h err=%b, want 7 40 0", lat, bin_a, err_a);
      end
      tick();
   endtask

   task automatic test_three_digit();
      logic [11:0] vin  [2] = '{12'h999, 12'h512};
      logic [9:0]  vexp [2] = '{10'd999, 10'd512};
      int lat;
      out_ready_b = 1'b1;
      for (int k = 0; k < 2; k++) begin
         run_b(vin[k], lat);
         n_cmp++;
         if (lat !== 10 || bin_b !== vexp[k] || err_b !== 1'b0) begin
            n_fail++;
            $display("FAIL three_digit_%0d: lat=%0d bin=%0d err=%b, want 10 %0d 0", k, lat, bin_b, err_b, vexp[k]);
         end
         tick();
      end
   endtask

   initial begin
      n_cmp       = 0;
      n_fail      = 0;
      rst_n       = 1'b0;
      bcd_a       = '0;
      in_valid_a  = 1'b0;
      out_ready_a = 1'b0;
      bcd_b       = '0;
      in_valid_b  = 1'b0;
      out_ready_b = 1'b0;
      test_reset();
      test_basic();
      test_back_to_back();
      test_invalid();
      test_backpressure();
      test_reset_mid_shift();
      test_three_digit();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
